tick_timer_sched: RTL and testbench

//  Shares one tick prescaler/countdown between N_REQ doorlock requesters (keypad beep,

---
 rtl/tick_sched_pkg.sv | 42 ++++
 rtl/tick_prescaler.sv | 34 +++
 rtl/tick_timer_sched.sv | 162 ++++++++++++++++
 tb/tb_tick_timer_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick timer scheduler.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, round-robin pick result type, rr_pick().
package tick_sched_pkg;

  // Widest supported requester set; rr_pick works on this width and is told
  // how many lanes are really populated.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request bit scanning upward from ptr+1, wrapping modulo n.
  // The previous winner (ptr) is therefore looked at last.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n);
    pick_t res;
    int    j;
    res = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      j = (int'(ptr) + i) % n;
      if ((i <= n) && !res.found && req_vec[j]) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick strobe every TICK_DIV enabled cycles.
// Latency: tick is a decode of the counter, high in the last cycle of each period.
// Backpressure: none; counting pauses while en is low, clr restarts the period.
//
// Ports: clk, rst (sync, active-high), clr (restart period), en (count),
//        tick (strobe, only while en).
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tick_timer_sched.sv
// Round-robin shares one tick countdown between N_REQ requesters, pulsing done/abort.
// Latency: req seen at edge k -> gnt (or done for zero duration) after edge k+1.
// Backpressure: one grant at a time; losing requesters simply wait with req held.
//
// Ports: clk, rst (sync, active-high); req[N_REQ] level requests;
//        dur[N_REQ*DUR_W] packed durations in ticks; gnt one-hot grant;
//        busy (RUN/DONE); tick strobe; done/abort one-cycle one-hot pulses.
module tick_timer_sched
  import tick_sched_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   tick,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       abort
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [N_REQ-1:0]   win_oh_q, win_oh_d;
  logic [N_REQ-1:0]   req_q;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   abort_q, abort_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;

  logic [MAX_REQ-1:0] req_pad;
  pick_t              pick;
  logic [N_REQ-1:0]   pick_oh;
  logic [DUR_W-1:0]   pick_dur;
  logic               pre_clr;
  logic               pre_en;
  logic               pre_wrap;

  assign pre_en = (state_q == ST_RUN);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (pre_wrap)
  );

  // Arbitration works on the registered request so every decision and the
  // abort check see the same one-cycle-old view of req.
  always_comb begin
    req_pad = '0;
    req_pad[N_REQ-1:0] = req_q;
    pick = rr_pick(req_pad, rr_ptr_q, N_REQ);
    pick_oh  = '0;
    pick_dur = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick.found && (pick.idx == IDX_W'(i))) begin
        pick_oh[i] = 1'b1;
        pick_dur   = dur[i*DUR_W +: DUR_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rem_d    = rem_q;
    win_oh_d = win_oh_q;
    gnt_d    = '0;
    done_d   = '0;
    abort_d  = '0;
    tick_d   = 1'b0;
    pre_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          win_oh_d = pick_oh;
          rr_ptr_d = pick.idx;
          rem_d    = pick_dur;
          pre_clr  = 1'b1;
          if (pick_dur == '0) begin
            // Nothing to time: report completion without ever granting.
            state_d = ST_DONE;
            done_d  = pick_oh;
          end else begin
            state_d = ST_RUN;
            gnt_d   = pick_oh;
          end
        end
      end
      ST_RUN: begin
        tick_d = pre_wrap;
        if ((req_q & win_oh_q) == '0) begin
          // A dropped request wins over a completion landing on the same edge.
          state_d = ST_IDLE;
          abort_d = win_oh_q;
        end else if (pre_wrap) begin
          rem_d = (rem_q != '0) ? rem_q - DUR_W'(1) : rem_q;
          if (rem_q == DUR_W'(1)) begin
            state_d = ST_DONE;
            done_d  = win_oh_q;
          end else begin
            gnt_d = win_oh_q;
          end
        end else begin
          gnt_d = win_oh_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      rem_q    <= '0;
      win_oh_q <= '0;
      req_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      abort_q  <= '0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rem_q    <= rem_d;
      win_oh_q <= win_oh_d;
      req_q    <= req;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign tick  = tick_q;
  assign done  = done_q;
  assign abort = abort_q;

endmodule

// File: tb/tb_tick_timer_sched.sv
module tb_tick_timer_sched;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] dur = '0;
  logic [N-1:0]    gnt, done, abort;
  logic            busy, tick;

  tick_timer_sched #(.N_REQ(N), .DUR_W(DW), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .req(req), .dur(dur),
    .gnt(gnt), .busy(busy), .tick(tick), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endfunction

  // Scoreboard entries: completion/abort events stamped with the cycle they are due.
  typedef struct {
    int           at;
    logic [N-1:0] dn;
    logic [N-1:0] ab;
  } ev_t;
  ev_t evq[$];

  // Reference model: a grant is a window of cycles [m_lo, m_hi] of length
  // dur*TD; the arbiter becomes free again at cycle m_free. Requests are seen
  // one cycle late (m_reqq), as the block registers them.
  int           m_owner = -1;
  int           m_lo = 0, m_hi = 0, m_free = 0, m_ptr = N - 1;
  logic [N-1:0] m_reqq = '0;
  logic [N-1:0] exp_gnt = '0;
  logic         exp_tick = 1'b0, exp_busy = 1'b0;

  always @(posedge clk) begin
    int p, c, w, d, j;
    logic [N-1:0] evd, eva;
    p = cyc; c = cyc + 1; cyc = c;
    evd = '0; eva = '0; exp_tick = 1'b0;
    if (rst) begin
      m_owner = -1; m_ptr = N - 1; m_reqq = '0; m_free = c;
    end else begin
      if (m_owner >= 0 && p >= m_lo && p <= m_hi) begin
        if ((p - m_lo) % TD == TD - 1) exp_tick = 1'b1;
        if (!m_reqq[m_owner]) begin
          eva[m_owner] = 1'b1; m_owner = -1; m_free = c;
        end else if (p == m_hi) begin
          evd[m_owner] = 1'b1; m_owner = -1; m_free = c + 1;
        end
      end else if (m_owner < 0 && p >= m_free && m_reqq != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && m_reqq[j]) w = j;
        end
        m_ptr = w;
        d = int'(dur[w*DW +: DW]);
        if (d == 0) begin
          evd[w] = 1'b1; m_free = c + 1;
        end else begin
          m_owner = w; m_lo = c; m_hi = c + d * TD - 1;
        end
      end
      m_reqq = req;
    end
    exp_gnt = '0;
    if (m_owner >= 0 && c >= m_lo && c <= m_hi) exp_gnt[m_owner] = 1'b1;
    exp_busy = (exp_gnt != '0) || (evd != '0);
    if (evd != '0 || eva != '0) evq.push_back('{c, evd, eva});
  end

  // Monitor: compares level outputs every cycle and pops events as they appear.
  always @(negedge clk) begin
    ev_t e;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("busy", 32'(busy), 32'(exp_busy));
    check("tick", 32'(tick), 32'(exp_tick));
    while (evq.size() > 0 && evq[0].at < cyc) begin
      e = evq.pop_front();
      check("ev_missed", cyc, e.at);
    end
    if (done != '0 || abort != '0) begin
      if (evq.size() == 0) begin
        check("ev_unexpected", 32'({done, abort}), 32'(0));
      end else begin
        e = evq.pop_front();
        check("ev_cyc", cyc, e.at);
        check("ev_done", 32'(done), 32'(e.dn));
        check("ev_abort", 32'(abort), 32'(e.ab));
      end
    end
  end

  task automatic set_dur(input int i, input int v);
    dur[i*DW +: DW] = DW'(v);
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(input string nm, output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        break;
      end
    end
    check(nm, 32'(g != '0), 32'(1));
  endtask

  task automatic wait_evt(input string nm);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done != '0 || abort != '0) begin
        seen = 1'b1;
        break;
      end
    end
    check(nm, 32'(seen), 32'(1));
  endtask

  task automatic measure(output int ng, output int nt, output logic fin);
    ng = 0; nt = 0; fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge clk);
      if (gnt != '0) ng++;
      if (tick) nt++;
      if (done != '0 || abort != '0) fin = 1'b1;
    end
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] order [4];
    logic         fin;
    int           ng, nt;

    order = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single requester, duration 3.
    set_dur(1, 3); req = 3'b010;
    measure(ng, nt, fin);
    check("single_fin", 32'(fin), 32'(1));
    check("single_done", 32'(done), 32'(3'b010));
    check("single_len", ng, 12);
    check("single_ticks", nt, 3);
    idle(4);

    // Contention after reset, all durations 1.
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    set_dur(0, 1); set_dur(1, 1); set_dur(2, 1); req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt("cont_to", g);
      check("cont_order", 32'(g), 32'(order[i]));
      for (int k = 0; k < 50 && gnt != '0; k++) @(negedge clk);
    end
    idle(6);

    // Zero duration: done two edges after the request, never a grant.
    set_dur(0, 0); req = 3'b001;
    @(negedge clk);
    check("zero_gnt", 32'(gnt), 32'(0));
    @(negedge clk);
    check("zero_done", 32'(done), 32'(3'b001));
    req = '0;
    idle(4);

    // Abort of a long grant, pending requester 0 served next.
    set_dur(2, 5); set_dur(0, 2); req = 3'b100;
    wait_gnt("abort_to", g);
    check("abort_gnt", 32'(g), 32'(3'b100));
    req = 3'b101;
    repeat (5) @(negedge clk);
    req = 3'b001;
    wait_evt("abort_evt");
    check("abort_vec", 32'(abort), 32'(3'b100));
    check("abort_nodone", 32'(done), 32'(0));
    wait_gnt("abort_next_to", g);
    check("abort_next", 32'(g), 32'(3'b001));
    idle(12);

    // Reset in the middle of a run, then a full restart.
    set_dur(1, 3); req = 3'b010;
    wait_gnt("rst_to", g);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'(0));
    rst = 1'b0;
    measure(ng, nt, fin);
    check("rst_done", 32'(done), 32'(3'b010));
    check("rst_len", ng, 12);
    idle(4);

    // Request dropped exactly as the countdown would finish.
    set_dur(1, 1); req = 3'b010;
    wait_gnt("edge_to", g);
    repeat (2) @(negedge clk);
    req = '0;
    wait_evt("edge_evt");
    check("edge_abort", 32'(abort), 32'(3'b010));
    check("edge_nodone", 32'(done), 32'(0));
    idle(4);

    // Random traffic: requests rise/drop, durations wander, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          set_dur(i, int'($urandom_range(0, 3)));
        end
        if ($urandom_range(0, 29) == 0) set_dur(i, int'($urandom_range(0, 3)));
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle(60);
    check("drain", evq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
